// File: rtl/scan_config_ctrl.sv
// Scan-chain configuration loader: streams DATA_WIDTH-bit words LSB first into
// the CLB chain and then the connection chain, each for its latched bit length.
module scan_config_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  clb_len,
  input  logic [LEN_WIDTH-1:0]  conn_len,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  clb_scan_in,
  output logic                  clb_scan_en,
  output logic                  conn_scan_in,
  output logic                  conn_scan_en,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_CLB  = 2'd1,
    S_LOAD_CONN = 2'd2,
    S_FINISH    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [LEN_WIDTH-1:0]  r_clb_rem;
  logic [LEN_WIDTH-1:0]  r_conn_rem;
  logic                  r_clb_scan_in;
  logic                  r_clb_scan_en;
  logic                  r_conn_scan_in;
  logic                  r_conn_scan_en;

  logic                  w_in_load;
  logic                  w_has_bit;
  logic                  w_xfer;
  logic                  w_shift;
  logic                  w_last;
  logic [LEN_WIDTH-1:0]  w_rem_cur;

  assign w_in_load = (r_state == S_LOAD_CLB) || (r_state == S_LOAD_CONN);
  assign w_has_bit = (r_cnt != {CNT_W{1'b0}});
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_shift   = w_in_load && w_has_bit;
  assign w_rem_cur = (r_state == S_LOAD_CLB) ? r_clb_rem : r_conn_rem;
  // Last bit of the active chain: leftover bits of the word are dropped.
  assign w_last    = w_shift && (w_rem_cur == LEN_ONE);

  assign clb_scan_in  = r_clb_scan_in;
  assign clb_scan_en  = r_clb_scan_en;
  assign conn_scan_in = r_conn_scan_in;
  assign conn_scan_en = r_conn_scan_en;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!start) begin
          w_next_state = S_IDLE;
        end else if (clb_len != LEN_ZERO) begin
          w_next_state = S_LOAD_CLB;
        end else if (conn_len != LEN_ZERO) begin
          w_next_state = S_LOAD_CONN;
        end else begin
          w_next_state = S_FINISH;
        end
      end
      S_LOAD_CLB: begin
        if (!w_last) begin
          w_next_state = S_LOAD_CLB;
        end else if (r_conn_rem != LEN_ZERO) begin
          w_next_state = S_LOAD_CONN;
        end else begin
          w_next_state = S_FINISH;
        end
      end
      S_LOAD_CONN: begin
        if (w_last) begin
          w_next_state = S_FINISH;
        end else begin
          w_next_state = S_LOAD_CONN;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
      end
      S_LOAD_CLB, S_LOAD_CONN: begin
        cfg_ready = !w_has_bit;
        busy      = 1'b1;
      end
      S_FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
      end
    endcase
  end

  // Word shift register and count of bits still held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= {DATA_WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else if (w_xfer) begin
      r_shift <= cfg_data;
      r_cnt   <= CNT_FULL;
    end else if (w_last) begin
      r_shift <= {DATA_WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else if (w_shift) begin
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_cnt   <= r_cnt - CNT_ONE;
    end
  end

  // Remaining per-chain lengths, latched on an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clb_rem  <= LEN_ZERO;
      r_conn_rem <= LEN_ZERO;
    end else if ((r_state == S_IDLE) && start) begin
      r_clb_rem  <= clb_len;
      r_conn_rem <= conn_len;
    end else if (w_shift && (r_state == S_LOAD_CLB)) begin
      r_clb_rem  <= r_clb_rem - LEN_ONE;
    end else if (w_shift && (r_state == S_LOAD_CONN)) begin
      r_conn_rem <= r_conn_rem - LEN_ONE;
    end
  end

  // Registered scan outputs; the idle chain is held at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clb_scan_en  <= 1'b0;
      r_clb_scan_in  <= 1'b0;
      r_conn_scan_en <= 1'b0;
      r_conn_scan_in <= 1'b0;
    end else begin
      r_clb_scan_en  <= w_shift && (r_state == S_LOAD_CLB);
      r_clb_scan_in  <= w_shift && (r_state == S_LOAD_CLB) && r_shift[0];
      r_conn_scan_en <= w_shift && (r_state == S_LOAD_CONN);
      r_conn_scan_in <= w_shift && (r_state == S_LOAD_CONN) && r_shift[0];
    end
  end

endmodule

// File: doc/scan_config_ctrl.md
SCAN_CONFIG_CTRL -- requirements
Module: scan_config_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one configuration word.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of the per-chain bit-length inputs.
REQ-003 SHALL have port clk, input, 1: the only clock; all state is rising-edge triggered.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a configuration load.
REQ-006 SHALL have port clb_len, input, LEN_WIDTH: number of bits to shift into the CLB chain.
REQ-007 SHALL have port conn_len, input, LEN_WIDTH: number of bits to shift into the connection chain.
REQ-008 SHALL have port cfg_data, input, DATA_WIDTH: configuration word, shifted LSB first.
REQ-009 SHALL have port cfg_valid, input, 1: cfg_data holds a valid word.
REQ-010 SHALL have port cfg_ready, output, 1: the block accepts cfg_data this cycle.
REQ-011 SHALL have ports clb_scan_in and clb_scan_en, outputs, 1 each: drive the CLB scan chain.
REQ-012 SHALL have ports conn_scan_in and conn_scan_en, outputs, 1 each: drive the connection (switch block / connection block) chain.
REQ-013 SHALL have port busy, output, 1: a load is in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a load completes.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD_CLB, LOAD_CONN and FINISH.
REQ-016 IDLE: on start=1, SHALL latch clb_len and conn_len; next state is LOAD_CLB if clb_len!=0, else LOAD_CONN if conn_len!=0, else FINISH.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 SHALL hold an internal DATA_WIDTH shift register plus a bit count; cfg_ready SHALL equal 1 only in LOAD_CLB or LOAD_CONN while the shift register is empty (combinational from registered state).
REQ-019 A transfer SHALL occur when cfg_valid&&cfg_ready; the word is loaded into the shift register, with DATA_WIDTH bits available.
REQ-020 In each cycle of a LOAD state where the register holds at least one bit, SHALL on the next edge set the active chain's scan_en=1 and scan_in=current LSB, shift right, decrement the bit count and decrement the remaining chain length.
REQ-021 SHALL register the scan outputs; scan_en SHALL be 0 in any cycle with no bit to shift (stall), and the chain SHALL NOT advance during a stall.
REQ-022 The inactive chain's scan_en and scan_in SHALL be 0.
REQ-023 Each chain SHALL receive exactly its latched length of scan_en=1 cycles, which need not be contiguous.
REQ-024 When the remaining length reaches 0 mid-word, SHALL discard the unused bits; the next chain SHALL start from a fresh word.
REQ-025 LOAD_CLB -> LOAD_CONN when the CLB length is exhausted and conn_len!=0; otherwise -> FINISH.
REQ-026 LOAD_CONN -> FINISH when the connection length is exhausted.
REQ-027 FINISH SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-028 busy SHALL be 1 in LOAD_CLB, LOAD_CONN and FINISH, and 0 in IDLE.
REQ-029 The consecutive-cycle throughput with cfg_valid held high SHALL be DATA_WIDTH bits per DATA_WIDTH+1 cycles (one refill cycle per word).

Reset
REQ-030 rst=1 SHALL asynchronously force state IDLE, clear the shift register, bit count and lengths, and drive cfg_ready, all scan_in/scan_en, busy and done to 0.
REQ-031 A reset asserted mid-load SHALL abort the load without a done pulse; the next start SHALL begin a full new load.

Verification
REQ-032 clb_len=5, conn_len=0, word 8'b1011_0110 -> clb_scan_en high for 5 cycles, clb_scan_in 0,1,1,0,1; conn_scan_en never high; done pulses once.
REQ-033 clb_len=3, conn_len=10, words 0xFF, 0x55, 0x03 -> CLB gets 1,1,1; the rest of 0xFF is dropped; conn gets 1,0,1,0,1,0,1,0 then 1,1; 3 words consumed.
REQ-034 clb_len=0, conn_len=0, start -> FINISH next, done=1 for 1 cycle, cfg_ready never 1, no scan_en.
REQ-035 clb_len=16 with cfg_valid toggling randomly -> exactly 16 clb_scan_en cycles; bit order matches the words, LSB first; no bit lost or duplicated on stalls.
REQ-036 rst pulsed after 4 of 8 bits shifted -> all outputs 0 immediately, no done pulse; a following start with clb_len=8 shifts the full new word.
REQ-037 start pulsed while busy=1 -> no effect on lengths or sequence.
